// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch_unit_if : instruction-memory read bus, master/slave view |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface instr_fetch_unit_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch_unit : single-word fetch FSM with timeout and IR decode  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module instr_fetch_unit #(
  parameter int          TIMEOUT  = 15,
  parameter logic [15:0] RESET_IR = 16'hF000
) (
  input  logic               clk,
  input  logic               proc_rst,
  input  logic               fetch_start,
  input  logic               flush,
  input  logic [15:0]        pc_in,
  instr_fetch_unit_if.master mem,
  output logic [15:0]        IR,
  output logic               ir_valid,
  output logic [15:0]        pc_next,
  output logic               illegal,
  output logic               mask_zero,
  output logic               busy,
  output logic               fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [7:0] c_timeout = 8'(TIMEOUT);

  state_t      state_q;
  logic [15:0] addr_q;
  logic [15:0] ir_q;
  logic [15:0] pc_next_q;
  logic [7:0]  cnt_q;
  logic        mem_req_q;
  logic        ir_valid_q;
  logic        busy_q;
  logic        err_q;

  logic [7:0]  cnt_d;
  logic [15:0] pc_next_d;

  assign cnt_d     = cnt_q + 8'd1;
  assign pc_next_d = pc_in + 16'd1;

  always_ff @(posedge clk or negedge proc_rst) begin
    if (!proc_rst) begin
      state_q    <= S_IDLE;
      addr_q     <= 16'h0000;
      ir_q       <= RESET_IR;
      pc_next_q  <= 16'h0000;
      cnt_q      <= 8'd0;
      mem_req_q  <= 1'b0;
      ir_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else if (flush) begin
      // Abort wins over start and ack; IR and the error flag survive.
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      mem_req_q  <= 1'b0;
      ir_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (fetch_start) begin
            state_q    <= S_REQ;
            addr_q     <= pc_in;
            pc_next_q  <= pc_next_d;
            cnt_q      <= 8'd0;
            mem_req_q  <= 1'b1;
            ir_valid_q <= 1'b0;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
          end
        end
        S_REQ: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          // An ack on the final allowed cycle still completes the fetch.
          if (mem.mem_ack) begin
            state_q    <= S_DONE;
            ir_q       <= mem.mem_rdata;
            ir_valid_q <= 1'b1;
            mem_req_q  <= 1'b0;
            busy_q     <= 1'b0;
          end else if (cnt_d == c_timeout) begin
            state_q   <= S_ERR;
            err_q     <= 1'b1;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = addr_q;

  assign IR        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign pc_next   = pc_next_q;
  assign busy      = busy_q;
  assign fetch_err = err_q;
  assign mask_zero = (ir_q[7:0] == 8'h00);
  assign illegal   = ir_valid_q &&
                     (ir_q[15:12] inside {4'd10, 4'd11, 4'd13, 4'd14, 4'd15});

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_fetch_unit : directed bench with expectation queue/monitor  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_instr_fetch_unit;

  logic        clk;
  logic        proc_rst;
  logic        fetch_start;
  logic        flush;
  logic [15:0] pc_in;
  logic [15:0] IR;
  logic        ir_valid;
  logic [15:0] pc_next;
  logic        illegal;
  logic        mask_zero;
  logic        busy;
  logic        fetch_err;

  instr_fetch_unit_if mif ();

  instr_fetch_unit #(
    .TIMEOUT  (3),
    .RESET_IR (16'hF000)
  ) dut (
    .clk         (clk),
    .proc_rst    (proc_rst),
    .fetch_start (fetch_start),
    .flush       (flush),
    .pc_in       (pc_in),
    .mem         (mif),
    .IR          (IR),
    .ir_valid    (ir_valid),
    .pc_next     (pc_next),
    .illegal     (illegal),
    .mask_zero   (mask_zero),
    .busy        (busy),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [15:0] ir;
    logic [15:0] pcn;
    bit          ill;
    bit          mz;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Completion/error monitor: pops one expectation per rising ir_valid or fetch_err.
  bit prev_v = 1'b0;
  bit prev_e = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if ((ir_valid && !prev_v) || (fetch_err && !prev_e)) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_event: actual valid=%b err=%b required no event", ir_valid, fetch_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_kind", {15'd0, fetch_err}, {15'd0, e.is_err});
        chk("mon_ir", IR, e.ir);
        if (!e.is_err) chk("mon_pc_next", pc_next, e.pcn);
        chk("mon_illegal", {15'd0, illegal}, {15'd0, e.ill});
        chk("mon_mask_zero", {15'd0, mask_zero}, {15'd0, e.mz});
        chk("mon_mem_req", {15'd0, mif.mem_req}, 16'd0);
      end
    end
    prev_v = ir_valid;
    prev_e = fetch_err;
  end

  task automatic do_fetch(input logic [15:0] pc, input logic [15:0] rd, input int delay,
                          input bit poke, input logic [15:0] pcn, input bit ill, input bit mz);
    @(negedge clk);
    fetch_start = 1'b1;
    pc_in       = pc;
    @(posedge clk); #1;
    chk("start_mem_req", {15'd0, mif.mem_req}, 16'd1);
    chk("start_mem_addr", mif.mem_addr, pc);
    chk("start_busy", {15'd0, busy}, 16'd1);
    chk("start_ir_valid", {15'd0, ir_valid}, 16'd0);
    chk("start_fetch_err", {15'd0, fetch_err}, 16'd0);
    @(negedge clk);
    fetch_start = 1'b0;
    @(posedge clk); #1;
    chk("wait_mem_req", {15'd0, mif.mem_req}, 16'd1);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      fetch_start = poke && (i == 0);
      pc_in       = 16'h0500;
      @(posedge clk); #1;
      chk("hold_mem_req", {15'd0, mif.mem_req}, 16'd1);
      chk("hold_mem_addr", mif.mem_addr, pc);
    end
    @(negedge clk);
    fetch_start   = 1'b0;
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = rd;
    sb.push_back('{1'b0, rd, pcn, ill, mz});
    @(posedge clk); #1;
    chk("done_busy", {15'd0, busy}, 16'd0);
    chk("done_mem_req", {15'd0, mif.mem_req}, 16'd0);
    @(negedge clk);
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 16'hBEEF;
  endtask

  task automatic start_to_wait(input logic [15:0] pc);
    @(negedge clk);
    fetch_start = 1'b1;
    pc_in       = pc;
    @(posedge clk);
    @(negedge clk);
    fetch_start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    proc_rst      = 1'b1;
    fetch_start   = 1'b0;
    flush         = 1'b0;
    pc_in         = 16'h0000;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 16'h0000;

    #2 proc_rst = 1'b0;
    #1;
    chk("rst_ir", IR, 16'hF000);
    chk("rst_mem_req", {15'd0, mif.mem_req}, 16'd0);
    chk("rst_mem_addr", mif.mem_addr, 16'h0000);
    chk("rst_ir_valid", {15'd0, ir_valid}, 16'd0);
    chk("rst_pc_next", pc_next, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_fetch_err", {15'd0, fetch_err}, 16'd0);
    chk("rst_illegal", {15'd0, illegal}, 16'd0);
    chk("rst_mask_zero", {15'd0, mask_zero}, 16'd1);

    @(negedge clk) proc_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", {15'd0, busy}, 16'd0);
    chk("idle_mem_req", {15'd0, mif.mem_req}, 16'd0);

    // Ack while idle must not load IR.
    @(negedge clk);
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 16'h1111;
    @(posedge clk); #1;
    chk("idle_ack_ir", IR, 16'hF000);
    chk("idle_ack_valid", {15'd0, ir_valid}, 16'd0);
    @(negedge clk) mif.mem_ack = 1'b0;

    do_fetch(16'h0010, 16'h1234, 0, 1'b0, 16'h0011, 1'b0, 1'b0);
    do_fetch(16'hFFFF, 16'hA0C5, 1, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_fetch(16'h0100, 16'h7000, 2, 1'b0, 16'h0101, 1'b0, 1'b1);
    do_fetch(16'h0200, 16'h7081, 0, 1'b0, 16'h0201, 1'b0, 1'b0);

    // Timeout with no ack: ERR after three WAIT cycles.
    @(negedge clk);
    fetch_start = 1'b1;
    pc_in       = 16'h0300;
    sb.push_back('{1'b1, 16'h7081, 16'h0000, 1'b0, 1'b0});
    @(posedge clk);
    @(negedge clk) fetch_start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("to_wait2_req", {15'd0, mif.mem_req}, 16'd1);
    @(posedge clk); #1;
    chk("to_wait3_req", {15'd0, mif.mem_req}, 16'd1);
    chk("to_wait3_err", {15'd0, fetch_err}, 16'd0);
    @(posedge clk); #1;
    chk("to_err_req", {15'd0, mif.mem_req}, 16'd0);
    chk("to_err_flag", {15'd0, fetch_err}, 16'd1);
    chk("to_err_busy", {15'd0, busy}, 16'd0);
    chk("to_err_ir", IR, 16'h7081);

    @(negedge clk);
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 16'hDEAD;
    @(posedge clk); #1;
    chk("err_ack_ir", IR, 16'h7081);
    chk("err_ack_valid", {15'd0, ir_valid}, 16'd0);
    @(negedge clk);
    mif.mem_ack = 1'b0;
    flush       = 1'b1;
    @(posedge clk); #1;
    chk("flush_keeps_err", {15'd0, fetch_err}, 16'd1);
    chk("flush_keeps_ir", IR, 16'h7081);
    @(negedge clk) flush = 1'b0;

    do_fetch(16'h0301, 16'hC00F, 0, 1'b0, 16'h0302, 1'b0, 1'b0);
    // fetch_start during WAIT is ignored; ack lands on the timeout cycle.
    do_fetch(16'h0400, 16'h9ABC, 2, 1'b1, 16'h0401, 1'b0, 1'b0);

    // Flush and ack together in WAIT: flush wins.
    start_to_wait(16'h0600);
    @(negedge clk);
    flush         = 1'b1;
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 16'h5555;
    @(posedge clk); #1;
    chk("flush_ack_busy", {15'd0, busy}, 16'd0);
    chk("flush_ack_req", {15'd0, mif.mem_req}, 16'd0);
    chk("flush_ack_valid", {15'd0, ir_valid}, 16'd0);
    chk("flush_ack_ir", IR, 16'h9ABC);
    @(negedge clk);
    flush       = 1'b0;
    mif.mem_ack = 1'b0;

    // Asynchronous reset mid-cycle during WAIT.
    start_to_wait(16'h0700);
    chk("pre_rst_req", {15'd0, mif.mem_req}, 16'd1);
    #2 proc_rst = 1'b0;
    #1;
    chk("async_rst_req", {15'd0, mif.mem_req}, 16'd0);
    chk("async_rst_ir", IR, 16'hF000);
    chk("async_rst_busy", {15'd0, busy}, 16'd0);
    chk("async_rst_addr", mif.mem_addr, 16'h0000);
    @(negedge clk) proc_rst = 1'b1;
    @(negedge clk);
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 16'h1111;
    @(posedge clk); #1;
    chk("post_rst_ack_ir", IR, 16'hF000);
    chk("post_rst_ack_valid", {15'd0, ir_valid}, 16'd0);
    @(negedge clk) mif.mem_ack = 1'b0;

    do_fetch(16'hFFFE, 16'hD000, 0, 1'b0, 16'hFFFF, 1'b1, 1'b1);

    @(negedge clk);
    chk("sb_drained", 16'(sb.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of WAIT cycles without mem_ack before an error (range 1..255).
REQ-002 SHALL have parameter RESET_IR, default 16'hF000, meaning the IR value after reset.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; clk and proc_rst are listed first below.
REQ-004 clk  in  1  single clock; all registers update on the rising edge.
REQ-005 proc_rst  in  1  asynchronous active-low reset.
REQ-006 fetch_start  in  1  one-cycle request from the controller to fetch the word at pc_in.
REQ-007 flush  in  1  synchronous abort of any fetch in progress.
REQ-008 pc_in  in  16  program counter value, sampled when a fetch is accepted.
REQ-009 mem_req  out  1  memory read request.
REQ-010 mem_addr  out  16  read address.
REQ-011 mem_ack  in  1  memory read-data-valid strobe.
REQ-012 mem_rdata  in  16  memory read data.
REQ-013 IR  out  16  instruction register, fed to the controller.
REQ-014 ir_valid  out  1  IR holds a freshly fetched word.
REQ-015 pc_next  out  16  captured PC plus 1.
REQ-016 illegal  out  1  the fetched opcode is not a supported one.
REQ-017 mask_zero  out  1  IR[7:0] equals 0 (empty LM/SM register list).
REQ-018 busy  out  1  a fetch is in progress.
REQ-019 fetch_err  out  1  the last fetch timed out.

Function
REQ-020 SHALL implement a five-state FSM: IDLE, REQ, WAIT, DONE, ERR.
REQ-021 IDLE/DONE/ERR + fetch_start=1: capture pc_in into the address register, clear ir_valid and fetch_err, go to REQ.
REQ-022 REQ: mem_req=1 and mem_addr=captured PC; go to WAIT unconditionally on the next edge.
REQ-023 WAIT: hold mem_req=1 and a stable mem_addr, and increment the timeout counter each cycle.
REQ-024 WAIT with mem_ack=1: load IR from mem_rdata on that edge, set ir_valid=1, go to DONE.
REQ-025 mem_ack is ignored in every state except WAIT.
REQ-026 WAIT with the counter reaching TIMEOUT and no ack: go to ERR, set fetch_err=1, leave IR unchanged, drop mem_req.
REQ-027 If mem_ack arrives on the same cycle the counter reaches TIMEOUT, the ack wins and the fetch completes.
REQ-028 Minimum latency: fetch_start accepted at edge N, mem_req high after N, ack sampled at N+2, ir_valid high after N+2.
REQ-029 ir_valid stays high throughout DONE and clears on the edge that accepts the next fetch_start.
REQ-030 fetch_start while in REQ or WAIT SHALL be ignored; there is no queueing.
REQ-031 flush=1 in any state: go to IDLE, clear mem_req, ir_valid and the counter; keep IR and fetch_err.
REQ-032 flush has priority over fetch_start and over mem_ack when they occur in the same cycle.
REQ-033 busy=1 exactly in REQ and WAIT.
REQ-034 mem_req is a registered output, decoded from the state register with no combinational path from any input.
REQ-035 pc_next = captured PC + 1, modulo 2^16, so 16'hFFFF wraps to 16'h0000; it is valid whenever ir_valid=1.
REQ-036 illegal = ir_valid AND IR[15:12] is in {10, 11, 13, 14, 15}; opcodes 0-9 and 12 are legal.
REQ-037 mask_zero = (IR[7:0] == 0); it is combinational from IR.
REQ-038 The timeout counter resets to 0 on every entry to REQ.

Reset
REQ-039 proc_rst=0 SHALL immediately force state IDLE, IR=RESET_IR, mem_req=0, mem_addr=0, ir_valid=0, pc_next=0, busy=0, fetch_err=0 and counter=0, regardless of clk.
REQ-040 Reset asserted mid-fetch SHALL drop mem_req asynchronously, and an ack arriving later SHALL be ignored.
REQ-041 After proc_rst deasserts, the FSM SHALL stay in IDLE until the first fetch_start.

Verification
REQ-042 pc_in=16'h0010, fetch_start pulse, ack after 1 WAIT cycle with rdata=16'h1234 -> mem_addr=0010, IR=1234, ir_valid=1, pc_next=0011, illegal=0.
REQ-043 pc_in=16'hFFFF, rdata=16'hA0C5 -> pc_next=0000, illegal=1.
REQ-044 TIMEOUT=3, no ack -> fetch_err=1 after 3 WAIT cycles, mem_req=0, IR unchanged; a retried fetch_start clears fetch_err.
REQ-045 flush and mem_ack in the same WAIT cycle -> state IDLE, IR unchanged, ir_valid=0.
REQ-046 proc_rst pulsed low mid-clock during WAIT -> mem_req=0 before the next edge, IR=F000, and a later ack has no effect.
REQ-047 rdata=16'h7000 -> mask_zero=1; rdata=16'h7081 -> mask_zero=0.
